keypad_matrix_responder: RTL and testbench

- Drives a 4x4 keypad matrix interface from the key side: it watches the one-hot row strobe from the keypad scanner and answers on the column lines.
- The answer imitates a physical key being pressed, held and released, with optional contact bounce on press and on release.
- It is the counterpart of the scanner. It sits in the simulation/self-test path so the Morse front end can be exercised without a physical keypad.
- Key requests arrive on a valid/ready handshake.

---
 rtl/keypad_matrix_responder_pkg.sv | 36 +++
 rtl/keypad_matrix_responder_contact_fsm.sv | 117 +++++++++++
 rtl/keypad_matrix_responder.sv | 78 +++++++
 tb/tb_keypad_matrix_responder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/keypad_matrix_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared types and helpers for the 4x4 keypad matrix (responder
//             and scanner side). Holds the press-phase state encoding, the
//             matrix dimensions and the key-index to row/col one-hot mapping.
//  Revision : 1.0  initial release
// ============================================================================
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BOUNCE_IN  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_BOUNCE_OUT = 3'd3,
    ST_GAP        = 3'd4
  } kp_state_e;

  typedef struct packed {
    logic [KP_ROWS-1:0] row_oh;
    logic [KP_COLS-1:0] col_oh;
  } kp_onehot_t;

  // Key index layout: row = key[3:2], column = key[1:0].
  function automatic kp_onehot_t kp_key_onehot(input logic [3:0] key);
    kp_onehot_t r;
    r.row_oh = KP_ROWS'(1) << key[3:2];
    r.col_oh = KP_COLS'(1) << key[1:0];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_matrix_responder_contact_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_contact_fsm
//  Purpose  : Accepts a key request on a valid/ready handshake and sequences
//             the imitated key contact through bounce-in, hold, bounce-out
//             and release gap.
//  Ports    : clk, rst         clock / synchronous active-high reset
//             req_valid/key    request in; req_ready high only in IDLE
//             busy             high outside IDLE
//             done             one-cycle pulse during the last GAP cycle
//             contact          current contact state (decoded from state)
//             key_row/key_col  latched key coordinates
//  Revision : 1.0  initial release
// ============================================================================
module keypad_contact_fsm
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES   = 64,
  parameter int BOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES    = 8,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [3:0] req_key,
  output logic       req_ready,
  output logic       busy,
  output logic       done,
  output logic       contact,
  output logic [1:0] key_row,
  output logic [1:0] key_col
);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam bit               HAS_BOUNCE  = (BOUNCE_CYCLES > 0);

  kp_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       key_q, key_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    key_d   = key_q;
    contact = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          key_d   = req_key;
          state_d = HAS_BOUNCE ? ST_BOUNCE_IN : ST_HOLD;
        end
      end
      ST_BOUNCE_IN: begin
        // First bounce cycle is closed.
        contact = ~cnt_q[0];
        if (cnt_q == BOUNCE_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        contact = 1'b1;
        if (cnt_q == HOLD_LAST) begin
          state_d = HAS_BOUNCE ? ST_BOUNCE_OUT : ST_GAP;
          cnt_d   = '0;
        end
      end
      ST_BOUNCE_OUT: begin
        // First bounce cycle is open.
        contact = cnt_q[0];
        if (cnt_q == BOUNCE_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Registered pulse: set on the edge that enters the final GAP cycle.
    done_d = (state_d == ST_GAP) && (cnt_d == GAP_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      done_q  <= done_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign key_row   = key_q[3:2];
  assign key_col   = key_q[1:0];

endmodule
`default_nettype wire

// File: rtl/keypad_matrix_responder.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_matrix_responder
//  Purpose  : Key-side model of a 4x4 keypad matrix. Watches the scanner's
//             row strobe and answers on the column lines as if a key were
//             pressed, held and released (with optional contact bounce).
//  Ports    : clk, rst   clock / synchronous active-high reset
//             row        row strobe from scanner (treated as bitwise OR)
//             col        registered column response, at most one bit set
//             req_*      key-press request handshake
//             busy/done  press in progress / end-of-press pulse
//  Revision : 1.0  initial release
// ============================================================================
module keypad_matrix_responder
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES   = 64,
  parameter int BOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES    = 8,
  parameter int CNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KP_ROWS-1:0] row,
  output logic [KP_COLS-1:0] col,
  input  logic               req_valid,
  input  logic [3:0]         req_key,
  output logic               req_ready,
  output logic               busy,
  output logic               done
);

  logic       contact;
  logic [1:0] key_row;
  logic [1:0] key_col;
  kp_onehot_t key_oh;

  logic [KP_COLS-1:0] col_q, col_d;

  keypad_contact_fsm #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .BOUNCE_CYCLES (BOUNCE_CYCLES),
    .GAP_CYCLES    (GAP_CYCLES),
    .CNT_W         (CNT_W)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_key   (req_key),
    .req_ready (req_ready),
    .busy      (busy),
    .done      (done),
    .contact   (contact),
    .key_row   (key_row),
    .key_col   (key_col)
  );

  always_comb begin
    key_oh = kp_key_onehot({key_row, key_col});
    col_d  = '0;
    // Any set row bit matching the key's row closes the circuit.
    if (contact && |(row & key_oh.row_oh)) begin
      col_d = key_oh.col_oh;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
    end else begin
      col_q <= col_d;
    end
  end

  assign col = col_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_matrix_responder
//  Purpose  : Directed self-checking bench. Instance A runs without bounce
//             (HOLD=8, GAP=8); instance B runs with default parameters.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_matrix_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row_a, row_b;
  logic [3:0] col_a, col_b;
  logic       req_valid_a, req_valid_b;
  logic [3:0] req_key_a, req_key_b;
  logic       req_ready_a, req_ready_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  keypad_matrix_responder #(
    .HOLD_CYCLES(8), .BOUNCE_CYCLES(0), .GAP_CYCLES(8), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst), .row(row_a), .col(col_a),
    .req_valid(req_valid_a), .req_key(req_key_a),
    .req_ready(req_ready_a), .busy(busy_a), .done(done_a)
  );

  keypad_matrix_responder dut_b (
    .clk(clk), .rst(rst), .row(row_b), .col(col_b),
    .req_valid(req_valid_b), .req_key(req_key_b),
    .req_ready(req_ready_b), .busy(busy_b), .done(done_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected contact for default parameters, j = cycles since accept.
  function automatic logic exp_contact_b(input int j);
    if (j < 4)       return (j % 2) == 0;
    else if (j < 68) return 1'b1;
    else if (j < 72) return ((j - 68) % 2) == 1;
    else             return 1'b0;
  endfunction

  initial begin
    logic [3:0] prev_row;
    rst = 1'b1;
    row_a = '0; row_b = '0;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    req_key_a = '0; req_key_b = '0;
    step();
    step();

    // 1: reset release with rotating rows
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      row_a = 4'(1 << i);
      row_b = 4'(1 << i);
      step();
      check("t1_col_a",   8'(col_a), 8'h0);
      check("t1_rdy_a",   8'(req_ready_a), 8'h1);
      check("t1_busy_a",  8'(busy_a), 8'h0);
      check("t1_done_a",  8'(done_a), 8'h0);
      check("t1_col_b",   8'(col_b), 8'h0);
      check("t1_rdy_b",   8'(req_ready_b), 8'h1);
    end

    // 2: no bounce, key row1/col2, row held at 0010
    row_a = 4'b0010;
    req_key_a = 4'b0110;
    req_valid_a = 1'b1;
    step();
    req_valid_a = 1'b0;
    check("t2_col_accept", 8'(col_a), 8'h0);
    check("t2_rdy_accept", 8'(req_ready_a), 8'h0);
    check("t2_busy_accept", 8'(busy_a), 8'h1);
    for (int k = 0; k < 8; k++) begin
      step();
      check("t2_hold_col", 8'(col_a), 8'h4);
      check("t2_hold_done", 8'(done_a), 8'h0);
    end
    for (int g = 0; g < 8; g++) begin
      step();
      check("t2_gap_col", 8'(col_a), 8'h0);
      check("t2_gap_done", 8'(done_a), (g == 6) ? 8'h1 : 8'h0);
    end
    check("t2_rdy_end",  8'(req_ready_a), 8'h1);
    check("t2_busy_end", 8'(busy_a), 8'h0);

    // 3: defaults, key 1111, row held at 1000
    row_b = 4'b1000;
    req_key_b = 4'b1111;
    req_valid_b = 1'b1;
    step();
    req_valid_b = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      step();
      check("t3_col", 8'(col_b), exp_contact_b(k - 1) ? 8'h8 : 8'h0);
      check("t3_done", 8'(done_b), (k == 79) ? 8'h1 : 8'h0);
      if (k == 79) check("t3_rdy_last_gap", 8'(req_ready_b), 8'h0);
    end
    check("t3_rdy_idle", 8'(req_ready_b), 8'h1);

    // 4: key 0001 with rotating rows during HOLD
    req_key_b = 4'b0001;
    req_valid_b = 1'b1;
    step();                                   // accept edge (step 0)
    req_valid_b = 1'b0;
    for (int k = 1; k <= 8; k++) step();
    // 5a: competing request during HOLD must be ignored
    req_key_b = 4'b0100;
    req_valid_b = 1'b1;
    for (int i = 0; i < 16; i++) begin        // steps 9..24
      prev_row = 4'(1 << (i % 4));
      row_b = prev_row;
      step();
      check("t4_rot_col", 8'(col_b), (prev_row == 4'b0001) ? 8'h2 : 8'h0);
      check("t5_rdy_hold", 8'(req_ready_b), 8'h0);
    end
    row_b = 4'b0010;
    for (int k = 25; k < 79; k++) step();
    step();                                   // step 79
    check("t5_done", 8'(done_b), 8'h1);
    step();                                   // step 80: IDLE
    check("t5_rdy_idle", 8'(req_ready_b), 8'h1);
    check("t5_done_clear", 8'(done_b), 8'h0);
    step();                                   // step 81: second accept
    req_valid_b = 1'b0;
    check("t5_busy_second", 8'(busy_b), 8'h1);
    check("t5_rdy_second", 8'(req_ready_b), 8'h0);
    step();                                   // step 82: first bounce closed
    check("t5_col_second", 8'(col_b), 8'h1);

    // 6: reset midway through HOLD on instance A
    row_a = 4'b0010;
    req_key_a = 4'b0110;
    req_valid_a = 1'b1;
    step();
    req_valid_a = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("t6_col_pre", 8'(col_a), 8'h4);
    rst = 1'b1;
    req_valid_a = 1'b1;
    step();
    rst = 1'b0;
    check("t6_col_rst",  8'(col_a), 8'h0);
    check("t6_rdy_rst",  8'(req_ready_a), 8'h1);
    check("t6_busy_rst", 8'(busy_a), 8'h0);
    check("t6_done_rst", 8'(done_a), 8'h0);
    step();
    req_valid_a = 1'b0;
    check("t6_busy_new", 8'(busy_a), 8'h1);
    step();
    check("t6_col_new", 8'(col_a), 8'h4);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t6_no_done", 8'(done_a), 8'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
